// File: rtl/freq_meter_pkg.sv
// ----------------------------------------------------------------------------
// freq_meter_pkg
// Shared definitions for the frequency/duty meter: FSM state encoding and
// the default parameter values used by freq_meter and sync_edge.
// ----------------------------------------------------------------------------
package freq_meter_pkg;

    localparam int FM_WIDTH_DEF       = 16;
    localparam int FM_SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_MEASURE = 2'd2
    } fm_state_e;

endpackage

// File: rtl/freq_meter_sync_edge.sv
// ----------------------------------------------------------------------------
// sync_edge
// Brings an asynchronous input into the clock domain through SYNC_STAGES
// flops and flags its rising edges.
//
// Ports:
//   clock  in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   d      in   asynchronous input
//   level  out  synchronized level (last synchronizer stage)
//   rise   out  high for one cycle when level goes 0 -> 1
//
// SYNC_STAGES must be at least 2.
// ----------------------------------------------------------------------------
module sync_edge
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = FM_SYNC_STAGES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    // r_prev lags level by one cycle, so rise can never be high two cycles
    // in a row.
    assign rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/freq_meter.sv
// ----------------------------------------------------------------------------
// freq_meter
// Measures the period (rise to rise) and high time of a slow asynchronous
// signal in system clock cycles.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   enable       in   1 = measure, 0 = idle and drop the measurement
//   sig_in       in   signal to measure (asynchronous)
//   period       out  cycles between the last two rises of sig_in
//   high_time    out  cycles sig_in was high within that period
//   valid        out  one-cycle pulse when period/high_time update
//   overflow     out  sticky: a period ran past 2**WIDTH-1 cycles
//   o_dbg_state  out  current FSM state (fm_state_e encoding)
//
// valid/data semantics: period and high_time change only in the cycle valid
// is high and hold until the next valid; there is no ready/back-pressure.
// ----------------------------------------------------------------------------
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int WIDTH       = FM_WIDTH_DEF,
    parameter int SYNC_STAGES = FM_SYNC_STAGES_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             valid,
    output logic             overflow,
    output logic [1:0]       o_dbg_state
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic w_level;
    logic w_rise;

    fm_state_e        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_hcnt, w_hcnt_nxt;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_time;
    logic             r_valid;
    logic             r_overflow;
    logic             w_capture;
    logic             w_ovf_set;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clock(clock),
        .reset(reset),
        .d    (sig_in),
        .level(w_level),
        .rise (w_rise)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hcnt_nxt  = r_hcnt;
        w_capture   = 1'b0;
        w_ovf_set   = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_hcnt_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_ARM;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = '0;
                end
                ST_ARM: begin
                    // The rise cycle itself counts as the first cycle of
                    // the period, and sig_in is high in it.
                    if (w_rise) begin
                        w_state_nxt = ST_MEASURE;
                        w_cnt_nxt   = CNT_ONE;
                        w_hcnt_nxt  = CNT_ONE;
                    end
                end
                ST_MEASURE: begin
                    // A rise on the saturating cycle still closes the period.
                    if (w_rise) begin
                        w_capture  = 1'b1;
                        w_cnt_nxt  = CNT_ONE;
                        w_hcnt_nxt = CNT_ONE;
                    end else if (r_cnt == CNT_MAX) begin
                        w_ovf_set   = 1'b1;
                        w_state_nxt = ST_ARM;
                        w_cnt_nxt   = '0;
                        w_hcnt_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                        if (w_level) begin
                            w_hcnt_nxt = r_hcnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_hcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_hcnt      <= '0;
            r_period    <= '0;
            r_high_time <= '0;
            r_valid     <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_valid <= w_capture;
            if (w_capture) begin
                r_period    <= r_cnt;
                r_high_time <= r_hcnt;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_capture || !enable) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign period      = r_period;
    assign high_time   = r_high_time;
    assign valid       = r_valid;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;
    import freq_meter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_n;
    logic en16, sig16, en4, sig4;

    logic [15:0] period16, high16;
    logic        valid16, ovf16;
    logic [1:0]  st16;
    logic [3:0]  period4, high4;
    logic        valid4, ovf4;
    logic [1:0]  st4;

    freq_meter #(.WIDTH(16), .SYNC_STAGES(2)) dut16 (
        .clock(clock), .reset(rst_n), .enable(en16), .sig_in(sig16),
        .period(period16), .high_time(high16), .valid(valid16),
        .overflow(ovf16), .o_dbg_state(st16)
    );

    freq_meter #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
        .clock(clock), .reset(rst_n), .enable(en4), .sig_in(sig4),
        .period(period4), .high_time(high4), .valid(valid4),
        .overflow(ovf4), .o_dbg_state(st4)
    );

    // ---------------- bookkeeping ----------------
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int nv16, fv16, lv16, nv4, fv4, lv4;
    int dbl = 0;
    logic pv16 = 1'b0, pv4 = 1'b0;
    logic [15:0] exp_p16, exp_h16;
    logic [3:0]  exp_p4, exp_h4;
    int c0, c1, c2, c3, c4, c5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge. Every valid pulse is
    // checked against the expected period/high time of the current pattern,
    // and consecutive valids must be exactly one period apart.
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (valid16) begin
            chk("v16_period", 32'(period16), 32'(exp_p16));
            chk("v16_high", 32'(high16), 32'(exp_h16));
            chk("v16_ovf", 32'(ovf16), 32'd0);
            if (nv16 > 0) chk("v16_gap", 32'(cyc - lv16), 32'(exp_p16));
            else fv16 = cyc;
            nv16++;
            lv16 = cyc;
        end
        if (valid4) begin
            chk("v4_period", 32'(period4), 32'(exp_p4));
            chk("v4_high", 32'(high4), 32'(exp_h4));
            chk("v4_ovf", 32'(ovf4), 32'd0);
            if (nv4 > 0) chk("v4_gap", 32'(cyc - lv4), 32'(exp_p4));
            else fv4 = cyc;
            nv4++;
            lv4 = cyc;
        end
        if (valid16 && pv16) dbl++;
        if (valid4 && pv4) dbl++;
        pv16 = valid16;
        pv4  = valid4;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive16(input logic lvl, input int n);
        sig16 = lvl;
        repeat (n) tick();
    endtask

    task automatic drive4(input logic lvl, input int n);
        sig4 = lvl;
        repeat (n) tick();
    endtask

    task automatic clr16();
        nv16 = 0; fv16 = -1; lv16 = 0;
    endtask

    task automatic clr4();
        nv4 = 0; fv4 = -1; lv4 = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        en16 = 1'b0; sig16 = 1'b0;
        en4  = 1'b0; sig4  = 1'b0;
        exp_p16 = '0; exp_h16 = '0; exp_p4 = '0; exp_h4 = '0;
        clr16(); clr4();

        // Reset state
        repeat (2) tick();
        chk("rst_period", 32'(period16), 32'd0);
        chk("rst_high", 32'(high16), 32'd0);
        chk("rst_valid", 32'(valid16), 32'd0);
        chk("rst_ovf", 32'(ovf16), 32'd0);
        chk("rst_state", 32'(st16), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        // Divide-by-3: 2 high / 1 low, 10 rises -> 9 valids of 3/2
        exp_p16 = 16'd3; exp_h16 = 16'd2;
        en16 = 1'b1;
        tick();
        chk("div3_arm", 32'(st16), 32'(ST_ARM));
        clr16();
        for (int i = 0; i < 10; i++) begin
            drive16(1'b1, 2);
            drive16(1'b0, 1);
        end
        drive16(1'b0, 3);
        chk("div3_count", 32'(nv16), 32'd9);
        chk("div3_period", 32'(period16), 32'd3);
        chk("div3_high", 32'(high16), 32'd2);

        // Square 1000: rise driven at c0 reaches the FSM at c0+3, so the
        // first valid is at c0+3+1000.
        en16 = 1'b0;
        drive16(1'b0, 2);
        chk("dis_idle", 32'(st16), 32'(ST_IDLE));
        chk("dis_keep_period", 32'(period16), 32'd3);
        en16 = 1'b1;
        tick();
        exp_p16 = 16'd1000; exp_h16 = 16'd500;
        clr16();
        c0 = cyc;
        drive16(1'b1, 500); drive16(1'b0, 500);
        drive16(1'b1, 500); drive16(1'b0, 500);
        drive16(1'b1, 5);
        chk("sq_first_valid", 32'(fv16), 32'(c0 + 1003));
        chk("sq_count", 32'(nv16), 32'd2);
        chk("sq_period", 32'(period16), 32'd1000);
        chk("sq_high", 32'(high16), 32'd500);

        // Enable dropped mid-period: nothing reported, outputs retained
        clr16();
        en16 = 1'b0;
        drive16(1'b1, 5); drive16(1'b0, 10);
        drive16(1'b1, 10); drive16(1'b0, 10);
        chk("drop_no_valid", 32'(nv16), 32'd0);
        chk("drop_period", 32'(period16), 32'd1000);
        chk("drop_high", 32'(high16), 32'd500);
        chk("drop_state", 32'(st16), 32'(ST_IDLE));
        en16 = 1'b1;
        tick();
        chk("reen_arm", 32'(st16), 32'(ST_ARM));
        exp_p16 = 16'd20; exp_h16 = 16'd10;
        clr16();
        c1 = cyc;
        for (int i = 0; i < 2; i++) begin
            drive16(1'b1, 10);
            drive16(1'b0, 10);
        end
        drive16(1'b1, 5);
        chk("reen_first_valid", 32'(fv16), 32'(c1 + 23));
        chk("reen_count", 32'(nv16), 32'd2);
        chk("reen_period", 32'(period16), 32'd20);

        // WIDTH=4 overflow: cnt=1 at c2+3, reaches 15 at c2+17, trips at c2+18
        en4 = 1'b1;
        tick();
        exp_p4 = 4'd8; exp_h4 = 4'd4;
        clr4();
        c2 = cyc;
        drive4(1'b1, 3);
        drive4(1'b0, 14);
        chk("ovf_before", 32'(ovf4), 32'd0);
        chk("ovf_before_state", 32'(st4), 32'(ST_MEASURE));
        tick();
        chk("ovf_set", 32'(ovf4), 32'd1);
        chk("ovf_state_arm", 32'(st4), 32'(ST_ARM));
        chk("ovf_period_kept", 32'(period4), 32'd0);
        chk("ovf_no_valid", 32'(nv4), 32'd0);
        drive4(1'b0, 10);
        chk("ovf_sticky", 32'(ovf4), 32'd1);
        // 8-cycle source: second rise at c3+8 -> valid at c3+11
        c3 = cyc;
        drive4(1'b1, 4); drive4(1'b0, 4); drive4(1'b1, 2);
        chk("ovf_hold_pre_valid", 32'(ovf4), 32'd1);
        tick();
        chk("ovf_cleared", 32'(ovf4), 32'd0);
        chk("p8_count", 32'(nv4), 32'd1);
        chk("p8_first_valid", 32'(fv4), 32'(c3 + 11));
        chk("p8_period", 32'(period4), 32'd8);
        chk("p8_high", 32'(high4), 32'd4);

        // Overflow cleared by enable=0
        en4 = 1'b0;
        drive4(1'b0, 3);
        en4 = 1'b1;
        tick();
        drive4(1'b1, 3);
        drive4(1'b0, 16);
        chk("ovf2_set", 32'(ovf4), 32'd1);
        en4 = 1'b0;
        tick();
        chk("ovf2_en_clear", 32'(ovf4), 32'd0);
        chk("ovf2_idle", 32'(st4), 32'(ST_IDLE));

        // Rises exactly 15 apart: rise wins over saturation
        en4 = 1'b1;
        tick();
        exp_p4 = 4'd15; exp_h4 = 4'd5;
        clr4();
        c4 = cyc;
        for (int i = 0; i < 2; i++) begin
            drive4(1'b1, 5);
            drive4(1'b0, 10);
        end
        drive4(1'b1, 5);
        chk("p15_count", 32'(nv4), 32'd2);
        chk("p15_first_valid", 32'(fv4), 32'(c4 + 18));
        chk("p15_period", 32'(period4), 32'd15);
        chk("p15_ovf", 32'(ovf4), 32'd0);

        // Asynchronous reset mid-period (dut16 measuring a 20-cycle wave)
        drive16(1'b0, 2);
        @(posedge clock);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_period", 32'(period16), 32'd0);
        chk("arst_high", 32'(high16), 32'd0);
        chk("arst_valid", 32'(valid16), 32'd0);
        chk("arst_ovf", 32'(ovf16), 32'd0);
        chk("arst_state", 32'(st16), 32'(ST_IDLE));
        chk("arst_period4", 32'(period4), 32'd0);
        sig16 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_arm", 32'(st16), 32'(ST_ARM));
        exp_p16 = 16'd6; exp_h16 = 16'd3;
        clr16();
        c5 = cyc;
        for (int i = 0; i < 2; i++) begin
            drive16(1'b1, 3);
            drive16(1'b0, 3);
        end
        drive16(1'b1, 5);
        chk("p6_first_valid", 32'(fv16), 32'(c5 + 9));
        chk("p6_count", 32'(nv16), 32'd2);
        chk("p6_period", 32'(period16), 32'd6);
        chk("p6_high", 32'(high16), 32'd3);

        chk("no_double_valid", 32'(dbl), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
